// File: rtl/sync_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sync_pkg
// Description : Shared types and defaults for the transducer sync scheduler.
//               Holds the scheduler state encoding, the default timing
//               parameters and a small counter-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package sync_pkg;

    // Default timing parameters (clk cycles / sync counts)
    localparam int c_DEF_PERIOD     = 2500;
    localparam int c_DEF_TOL        = 4;
    localparam int c_DEF_LOCK_COUNT = 4;
    localparam int c_DEF_MISS_LIMIT = 8;

    // Scheduler state encoding; the numeric values are visible on the
    // state output port, so they must stay stable.
    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKING  = 2'd1,
        ST_LOCKED   = 2'd2,
        ST_HOLDOVER = 2'd3
    } sched_state_e;

    // Bits needed to represent 0 .. n_values-1, never less than one bit.
    function automatic int cnt_width(input int n_values);
        return (n_values < 2) ? 1 : $clog2(n_values);
    endfunction

endpackage : sync_pkg
`default_nettype wire

// File: rtl/period_counter.sv
`default_nettype none
// ============================================================================
// Module      : period_counter
// Description : Free-running phase counter, 0..PERIOD-1, with a synchronous
//               realign input that forces the count to zero on the next
//               cycle (realign wins over the normal increment).
// Ports       : clk       - clock, rising edge
//               rst       - synchronous active-high reset (count -> 0)
//               i_realign - force count to 0 on the next cycle
//               o_count   - registered phase count
// Revision    : 1.0 - initial release
// ============================================================================
module period_counter
    import sync_pkg::*;
#(
    parameter int PERIOD = c_DEF_PERIOD
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_realign,
    output logic [$clog2(PERIOD)-1:0] o_count
);

    localparam int                 c_CNT_W = $clog2(PERIOD);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(PERIOD - 1);

    logic [c_CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_realign || (r_count == c_LAST)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule : period_counter
`default_nettype wire

// File: rtl/sync_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : sync_scheduler
// Description : Tracks an external sync pulse train against a local phase
//               counter, qualifies lock (UNLOCKED/LOCKING/LOCKED/HOLDOVER)
//               and commits staged phase frames at period boundaries.
// Ports       : clk          - clock, rising edge
//               rst          - synchronous active-high reset
//               sync_pulse   - one-cycle pulse per external sync edge
//               frame_valid  - staged frame waiting for commit
//               frame_ready  - frame can be accepted (no frame pending)
//               period_cnt   - phase counter 0..PERIOD-1
//               period_start - high while period_cnt == 0
//               commit       - one-cycle pulse: swap staged frame to active
//               state        - current scheduler state
//               locked       - high in LOCKED or HOLDOVER
//               sync_lost    - one-cycle pulse on a drop from lock
// Revision    : 1.0 - initial release
// ============================================================================
module sync_scheduler
    import sync_pkg::*;
#(
    parameter int PERIOD     = c_DEF_PERIOD,
    parameter int TOL        = c_DEF_TOL,
    parameter int LOCK_COUNT = c_DEF_LOCK_COUNT,
    parameter int MISS_LIMIT = c_DEF_MISS_LIMIT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sync_pulse,
    input  logic                      frame_valid,
    output logic                      frame_ready,
    output logic [$clog2(PERIOD)-1:0] period_cnt,
    output logic                      period_start,
    output logic                      commit,
    output logic [1:0]                state,
    output logic                      locked,
    output logic                      sync_lost
);

    localparam int c_CNT_W  = $clog2(PERIOD);
    localparam int c_GOOD_W = cnt_width(LOCK_COUNT + 1);
    localparam int c_MISS_W = cnt_width(MISS_LIMIT + 1);

    // Acceptance window edges and the phase at which a missing sync is judged
    localparam logic [c_CNT_W-1:0]  c_WIN_HI    = c_CNT_W'(PERIOD - TOL);
    localparam logic [c_CNT_W-1:0]  c_WIN_LO    = c_CNT_W'(TOL);
    localparam logic [c_CNT_W-1:0]  c_MISS_AT   = c_CNT_W'(TOL + 1);
    localparam logic [c_GOOD_W-1:0] c_GOOD_LAST = c_GOOD_W'(LOCK_COUNT - 1);
    localparam logic [c_MISS_W-1:0] c_MISS_LAST = c_MISS_W'(MISS_LIMIT - 1);

    logic [c_CNT_W-1:0]  w_cnt;
    sched_state_e        r_state;
    sched_state_e        w_state_nxt;
    logic [c_GOOD_W-1:0] r_good_cnt;
    logic [c_GOOD_W-1:0] w_good_nxt;
    logic [c_MISS_W-1:0] r_miss_cnt;
    logic [c_MISS_W-1:0] w_miss_nxt;
    logic                r_seen;
    logic                r_pending;
    logic                r_sync_lost;
    logic                w_lost;
    logic                w_in_window;
    logic                w_sync_in;
    logic                w_miss_slot;
    logic                w_miss_event;
    logic                w_period_start;
    logic                w_commit;
    logic                w_accept;

    // Every sync realigns the phase, whatever the lock state.
    period_counter #(
        .PERIOD (PERIOD)
    ) u_period_counter (
        .clk       (clk),
        .rst       (rst),
        .i_realign (sync_pulse),
        .o_count   (w_cnt)
    );

    assign w_in_window    = (w_cnt >= c_WIN_HI) || (w_cnt <= c_WIN_LO);
    assign w_sync_in      = sync_pulse && w_in_window;
    assign w_miss_slot    = (w_cnt == c_MISS_AT);
    // Only reached when no sync is present this cycle (sync has priority).
    assign w_miss_event   = w_miss_slot && !r_seen;
    assign w_period_start = (w_cnt == '0);
    // Uses the registered pending flag, so a frame accepted on a period
    // start waits for the following one.
    assign w_commit       = w_period_start && r_pending;
    assign w_accept       = frame_valid && !r_pending;

    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good_cnt;
        w_miss_nxt  = r_miss_cnt;
        w_lost      = 1'b0;
        if (sync_pulse) begin
            case (r_state)
                ST_UNLOCKED: begin
                    w_state_nxt = ST_LOCKING;
                    w_good_nxt  = '0;
                end
                ST_LOCKING: begin
                    if (w_in_window) begin
                        w_good_nxt = r_good_cnt + c_GOOD_W'(1);
                        if (r_good_cnt == c_GOOD_LAST) begin
                            w_state_nxt = ST_LOCKED;
                        end
                    end else begin
                        w_good_nxt = '0;
                    end
                end
                ST_LOCKED: begin
                    if (!w_in_window) begin
                        w_state_nxt = ST_UNLOCKED;
                        w_lost      = 1'b1;
                    end
                end
                ST_HOLDOVER: begin
                    if (w_in_window) begin
                        w_state_nxt = ST_LOCKED;
                        w_miss_nxt  = '0;
                    end else begin
                        w_state_nxt = ST_UNLOCKED;
                        w_lost      = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_UNLOCKED;
                end
            endcase
        end else if (w_miss_event) begin
            case (r_state)
                ST_LOCKING: begin
                    w_state_nxt = ST_UNLOCKED;
                end
                ST_LOCKED: begin
                    w_state_nxt = ST_HOLDOVER;
                    w_miss_nxt  = c_MISS_W'(1);
                end
                ST_HOLDOVER: begin
                    if (r_miss_cnt == c_MISS_LAST) begin
                        w_state_nxt = ST_UNLOCKED;
                        w_miss_nxt  = '0;
                        w_lost      = 1'b1;
                    end else begin
                        w_miss_nxt = r_miss_cnt + c_MISS_W'(1);
                    end
                end
                default: begin
                    // misses are meaningless while unlocked
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_UNLOCKED;
            r_good_cnt  <= '0;
            r_miss_cnt  <= '0;
            r_seen      <= 1'b0;
            r_pending   <= 1'b0;
            r_sync_lost <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_good_cnt  <= w_good_nxt;
            r_miss_cnt  <= w_miss_nxt;
            r_sync_lost <= w_lost;
            // seen covers one sync window; cleared once the window has closed
            if (w_sync_in) begin
                r_seen <= 1'b1;
            end else if (w_miss_slot) begin
                r_seen <= 1'b0;
            end
            if (w_commit) begin
                r_pending <= 1'b0;
            end else if (w_accept) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign frame_ready  = !r_pending;
    assign period_cnt   = w_cnt;
    assign period_start = w_period_start;
    assign commit       = w_commit;
    assign state        = r_state;
    assign locked       = (r_state == ST_LOCKED) || (r_state == ST_HOLDOVER);
    assign sync_lost    = r_sync_lost;

endmodule : sync_scheduler
`default_nettype wire

// File: tb/tb_sync_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_scheduler
// Description : Self-checking bench for sync_scheduler with a behavioural
//               reference model compared every cycle, plus directed
//               scenarios with literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_scheduler;

    localparam int P  = 100;
    localparam int T  = 2;
    localparam int LC = 3;
    localparam int ML = 2;
    localparam int CW = $clog2(P);

    localparam int M_UNLOCKED = 0;
    localparam int M_LOCKING  = 1;
    localparam int M_LOCKED   = 2;
    localparam int M_HOLDOVER = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sync_pulse = 1'b0;
    logic          frame_valid = 1'b0;
    logic          frame_ready;
    logic [CW-1:0] period_cnt;
    logic          period_start;
    logic          commit;
    logic [1:0]    state;
    logic          locked;
    logic          sync_lost;

    int checks = 0;
    int errors = 0;
    int n_commit = 0;
    int n_lost = 0;

    sync_scheduler #(
        .PERIOD     (P),
        .TOL        (T),
        .LOCK_COUNT (LC),
        .MISS_LIMIT (ML)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sync_pulse   (sync_pulse),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .period_cnt   (period_cnt),
        .period_start (period_start),
        .commit       (commit),
        .state        (state),
        .locked       (locked),
        .sync_lost    (sync_lost)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int m_cnt   = 0;
    int m_state = M_UNLOCKED;
    int m_good  = 0;
    int m_miss  = 0;
    bit m_seen  = 1'b0;
    bit m_pend  = 1'b0;
    bit m_lost  = 1'b0;
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        bit in_win;
        bit miss;
        bit do_commit;
        if (rst) begin
            m_cnt = 0; m_state = M_UNLOCKED; m_good = 0; m_miss = 0;
            m_seen = 1'b0; m_pend = 1'b0; m_lost = 1'b0; m_valid = 1'b1;
        end else if (m_valid) begin
            in_win    = (m_cnt >= P - T) || (m_cnt <= T);
            miss      = (m_cnt == T + 1) && !m_seen && !sync_pulse;
            do_commit = (m_cnt == 0) && m_pend;
            m_lost    = 1'b0;
            if (sync_pulse) begin
                if (m_state == M_UNLOCKED) begin
                    m_state = M_LOCKING; m_good = 0;
                end else if (m_state == M_LOCKING) begin
                    if (in_win) begin
                        m_good++;
                        if (m_good == LC) m_state = M_LOCKED;
                    end else begin
                        m_good = 0;
                    end
                end else if (m_state == M_LOCKED) begin
                    if (!in_win) begin m_state = M_UNLOCKED; m_lost = 1'b1; end
                end else begin
                    if (in_win) begin m_state = M_LOCKED; m_miss = 0; end
                    else begin m_state = M_UNLOCKED; m_lost = 1'b1; end
                end
            end else if (miss) begin
                if (m_state == M_LOCKING) begin
                    m_state = M_UNLOCKED;
                end else if (m_state == M_LOCKED) begin
                    m_state = M_HOLDOVER; m_miss = 1;
                end else if (m_state == M_HOLDOVER) begin
                    m_miss++;
                    if (m_miss == ML) begin m_state = M_UNLOCKED; m_miss = 0; m_lost = 1'b1; end
                end
            end
            if (sync_pulse && in_win) m_seen = 1'b1;
            else if (m_cnt == T + 1) m_seen = 1'b0;
            m_cnt = sync_pulse ? 0 : (m_cnt + 1) % P;
            if (do_commit) m_pend = 1'b0;
            else if (frame_valid) m_pend = 1'b1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [CW+6:0] exp_v;
        logic [CW+6:0] act_v;
        if (m_valid) begin
            exp_v = {m_cnt[CW-1:0], (m_cnt == 0), ((m_cnt == 0) && m_pend),
                     m_state[1:0], (m_state >= M_LOCKED), m_lost, !m_pend};
            act_v = {period_cnt, period_start, commit, state, locked,
                     sync_lost, frame_ready};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL cycle_compare t=%0t actual=%h required=%h (cnt,ps,commit,state,locked,lost,ready)",
                         $time, act_v, exp_v);
            end
            if (commit === 1'b1) n_commit++;
            if (sync_lost === 1'b1) n_lost++;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_sync();
        sync_pulse = 1'b1;
        wait_cycles(1);
        sync_pulse = 1'b0;
    endtask

    // from period_cnt==0, sync arrives when period_cnt==99 (in-window)
    task automatic period_sync();
        wait_cycles(P - 1);
        send_sync();
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        wait_cycles(3);
        rst = 1'b0;
        chk("rst_period_cnt", int'(period_cnt), 0);
        chk("rst_state", int'(state), M_UNLOCKED);
        chk("rst_frame_ready", int'(frame_ready), 1);
        chk("rst_locked", int'(locked), 0);

        // acquisition
        period_sync();
        chk("acq1_state", int'(state), M_LOCKING);
        period_sync();
        period_sync();
        chk("acq3_state", int'(state), M_LOCKING);
        period_sync();
        chk("acq4_state", int'(state), M_LOCKED);
        chk("acq4_locked", int'(locked), 1);
        chk("acq_no_lost", n_lost, 0);

        // one sync omitted -> holdover, then recover
        wait_cycles(104);
        chk("hold_state", int'(state), M_HOLDOVER);
        chk("hold_locked", int'(locked), 1);
        chk("hold_cnt", int'(period_cnt), 4);
        wait_cycles(95);
        send_sync();
        chk("recover_state", int'(state), M_LOCKED);

        // two syncs omitted -> unlocked with one sync_lost pulse
        wait_cycles(104);
        chk("hold2_state", int'(state), M_HOLDOVER);
        wait_cycles(100);
        chk("lost_state", int'(state), M_UNLOCKED);
        chk("lost_pulse", int'(sync_lost), 1);
        chk("lost_locked", int'(locked), 0);
        wait_cycles(1);
        chk("lost_pulse_end", int'(sync_lost), 0);
        chk("freerun_cnt", int'(period_cnt), 5);
        chk("lost_count", n_lost, 1);

        // relock, then an out-of-window sync
        wait_cycles(94);
        send_sync();
        period_sync();
        period_sync();
        period_sync();
        chk("relock_state", int'(state), M_LOCKED);
        wait_cycles(50);
        chk("oow_pre_cnt", int'(period_cnt), 50);
        send_sync();
        chk("oow_state", int'(state), M_UNLOCKED);
        chk("oow_lost", int'(sync_lost), 1);
        chk("oow_cnt", int'(period_cnt), 0);

        // frame_valid held while pending -> single commit at next phase 0
        wait_cycles(10);
        frame_valid = 1'b1;
        wait_cycles(1);
        chk("hs_ready_low", int'(frame_ready), 0);
        wait_cycles(20);
        frame_valid = 1'b0;
        wait_cycles(69);
        chk("hs_cnt_zero", int'(period_cnt), 0);
        chk("hs_commit", int'(commit), 1);
        wait_cycles(1);
        chk("hs_ready_high", int'(frame_ready), 1);
        chk("hs_commit_once", n_commit, 1);

        // accept on period_start does not commit in that period
        wait_cycles(99);
        chk("ps_no_commit", int'(commit), 0);
        frame_valid = 1'b1;
        wait_cycles(1);
        frame_valid = 1'b0;
        chk("ps_ready_low", int'(frame_ready), 0);
        wait_cycles(98);
        chk("ps_count_before", n_commit, 1);
        wait_cycles(1);
        chk("ps_commit", int'(commit), 1);
        wait_cycles(1);

        // late in-window sync creates a second period start that commits
        wait_cycles(99);
        frame_valid = 1'b1;
        wait_cycles(1);
        frame_valid = 1'b0;
        wait_cycles(1);
        chk("late_cnt", int'(period_cnt), 2);
        send_sync();
        chk("late_commit", int'(commit), 1);
        wait_cycles(1);
        chk("late_ready", int'(frame_ready), 1);
        wait_cycles(100);
        chk("late_commit_once", n_commit, 3);

        // reset while a frame is pending
        frame_valid = 1'b1;
        wait_cycles(1);
        frame_valid = 1'b0;
        chk("mid_ready_low", int'(frame_ready), 0);
        wait_cycles(5);
        rst = 1'b1;
        wait_cycles(1);
        chk("mid_rst_cnt", int'(period_cnt), 0);
        chk("mid_rst_state", int'(state), M_UNLOCKED);
        chk("mid_rst_ready", int'(frame_ready), 1);
        chk("mid_rst_commit", int'(commit), 0);
        chk("mid_rst_locked", int'(locked), 0);
        chk("mid_rst_lost", int'(sync_lost), 0);
        rst = 1'b0;
        wait_cycles(250);
        chk("mid_no_commit", n_commit, 3);
        chk("total_lost", n_lost, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_sync_scheduler
`default_nettype wire

// File: doc/sync_scheduler.md
SYNC_SCHEDULER -- requirements
Module: sync_scheduler

Interface
REQ-001 Parameter PERIOD, default 2500, clk cycles per transducer period.
REQ-002 Parameter TOL, default 4, sync acceptance half-window in cycles; legal when TOL < PERIOD/4.
REQ-003 Parameter LOCK_COUNT, default 4, consecutive in-window syncs required to declare lock.
REQ-004 Parameter MISS_LIMIT, default 8, consecutive missed syncs tolerated in holdover.
REQ-005 clk  in  1  clock; rising-edge only.
REQ-006 rst  in  1  reset; synchronous, active-high.
REQ-007 sync_pulse  in  1  one-cycle pulse per external sync rising edge, already synchronised.
REQ-008 frame_valid  in  1  new phase frame is staged and waiting for commit.
REQ-009 frame_ready  out  1  scheduler can accept a frame; equals !pending.
REQ-010 period_cnt  out  $clog2(PERIOD)  phase counter, 0..PERIOD-1.
REQ-011 period_start  out  1  high while period_cnt==0.
REQ-012 commit  out  1  one-cycle pulse; phase buffers swap staged frame into active.
REQ-013 state  out  2  current FSM state encoding.
REQ-014 locked  out  1  high in LOCKED or HOLDOVER.
REQ-015 sync_lost  out  1  one-cycle pulse on any drop to UNLOCKED from LOCKED or HOLDOVER.

Function
REQ-016 period_cnt SHALL increment each cycle, wrapping from PERIOD-1 to 0.
REQ-017 Realign: a sync_pulse at cycle t SHALL force period_cnt=0 at t+1 in every state, overriding increment.
REQ-018 Window: a sync is in-window when period_cnt >= PERIOD-TOL or period_cnt <= TOL at the sync cycle; otherwise out-of-window.
REQ-019 Flag seen SHALL set on an in-window sync; at the cycle period_cnt==TOL+1, seen==0 SHALL register a miss, and seen SHALL then clear.
REQ-020 States: UNLOCKED, LOCKING, LOCKED, HOLDOVER; counters good_cnt, miss_cnt.
REQ-021 UNLOCKED: any sync -> LOCKING, good_cnt=0; misses ignored.
REQ-022 LOCKING: in-window sync increments good_cnt; when it reaches LOCK_COUNT -> LOCKED; out-of-window sync sets good_cnt=0, stays LOCKING; miss -> UNLOCKED.
REQ-023 LOCKED: in-window sync stays; out-of-window sync -> UNLOCKED with sync_lost; miss -> HOLDOVER, miss_cnt=1.
REQ-024 HOLDOVER: in-window sync -> LOCKED, miss_cnt=0; out-of-window sync -> UNLOCKED with sync_lost; miss increments miss_cnt, and reaching MISS_LIMIT -> UNLOCKED with sync_lost.
REQ-025 Sync and miss evaluation in the same cycle: sync takes priority; miss discarded.
REQ-026 Handshake: frame accepted when frame_valid && frame_ready; pending=1 next cycle.
REQ-027 commit SHALL pulse in the cycle period_start==1 and pending==1 (registered value), regardless of state; pending clears next cycle.
REQ-028 Accept coinciding with period_start while pending==0 SHALL NOT commit in that period.
REQ-029 A late in-window sync (period_cnt<=TOL) creates a second period_start; a still-pending frame commits there, and at most one commit per accepted frame.
REQ-030 All outputs SHALL be registered or decoded from registers only; no combinational path from inputs to outputs except frame_ready from pending.

Reset
REQ-031 On rst: period_cnt=0, state=UNLOCKED, good_cnt=0, miss_cnt=0, seen=0, pending=0, commit=0, sync_lost=0, locked=0.
REQ-032 frame_ready SHALL be 1 in the first cycle after rst deasserts; a staged frame is discarded by reset mid-operation.

Structure
REQ-033 Package sync_pkg SHALL hold the state enum and default PERIOD/TOL/LOCK_COUNT/MISS_LIMIT constants.
REQ-034 Sub-module period_counter (wrap counter with synchronous realign input) SHALL implement REQ-016/017.

Verification (bench PERIOD=100, TOL=2, LOCK_COUNT=3, MISS_LIMIT=2)
REQ-035 Syncs every 100 cycles from reset -> LOCKING after 1st, LOCKED after 4th, locked=1, no sync_lost.
REQ-036 Locked, one sync omitted -> HOLDOVER at period_cnt==3, locked stays 1; next sync in-window -> LOCKED.
REQ-037 Locked, two syncs omitted -> UNLOCKED at 2nd miss, sync_lost one pulse, period_cnt free-runs.
REQ-038 Locked, sync at period_cnt==50 -> UNLOCKED, sync_lost pulse, period_cnt==0 next cycle.
REQ-039 frame_valid held while pending -> single accept, frame_ready low, commit exactly once at next period_cnt==0, frame_ready high after.
REQ-040 rst asserted mid-frame with pending=1 -> no commit afterwards, all outputs at reset values next cycle.
